// File: rtl/wb_port_scheduler_pkg.sv
// Shared definitions for the GPR writeback-port scheduler.
//   - default widths and requester count
//   - source-index enumeration (load unit sits on the fixed-priority index)
//   - zom encodings for the writeback result mux
//   - grant-rule tag used to decide when the round-robin pointer advances
package wb_port_scheduler_pkg;

  localparam int NSRC_DEF       = 7;
  localparam int ADDR_W_DEF     = 5;
  localparam int PRIO_SRC_DEF   = 0;
  localparam int STARVE_MAX_DEF = 7;

  // Result producers. LOAD occupies index 0 so it coincides with PRIO_SRC.
  typedef enum logic [2:0] {
    SRC_LOAD  = 3'd0,
    SRC_ALU   = 3'd1,
    SRC_SHIFT = 3'd2,
    SRC_MUL   = 3'd3,
    SRC_DIV   = 3'd4,
    SRC_SPR   = 3'd5,
    SRC_BRL   = 3'd6
  } wb_src_e;

  localparam logic [2:0] ZOM_DATA = 3'b000;
  localparam logic [2:0] ZOM_ZERO = 3'b001;
  localparam logic [2:0] ZOM_ONE  = 3'b010;
  localparam logic [2:0] ZOM_M1   = 3'b100;

  typedef enum logic [1:0] {
    GRANT_NONE   = 2'd0,
    GRANT_PRIO   = 2'd1,
    GRANT_STARVE = 2'd2,
    GRANT_RR     = 2'd3
  } grant_rule_e;

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker.
// Returns the first requester at or after ptr_i (scanning cyclically) that is
// set in req_i and not set in excl_i.
// Ports:
//   req_i   [N]  request vector
//   excl_i  [N]  indices never granted by this picker
//   ptr_i   [IW] scan start index
//   gnt_o   [N]  one-hot grant (zero when nothing eligible)
//   idx_o   [IW] binary index of the grant
//   valid_o      a grant exists
module wb_rr_pick #(
  parameter int N = 7,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [N-1:0]  excl_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic [N-1:0] elig;

  assign elig = req_i & ~excl_i;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!valid_o && elig[(int'(ptr_i) + k) % N]) begin
        valid_o                       = 1'b1;
        gnt_o[(int'(ptr_i) + k) % N]  = 1'b1;
        idx_o                         = IW'((int'(ptr_i) + k) % N);
      end
    end
  end

endmodule

// File: rtl/wb_port_scheduler.sv
// Writeback-port scheduler: arbitrates up to NSRC result producers onto the
// single GPR write port and registers the winner into one writeback slot.
// Ports:
//   clk, reset_n         clock, synchronous active-low reset
//   req_valid [NSRC]     per-requester write request
//   req_addr  [NSRC*AW]  per-requester target GPR (slice i = requester i)
//   req_zom   [NSRC*3]   per-requester constant override (000 = data)
//   req_ready [NSRC]     one-hot accept
//   flush                pipeline flush, drops the slot and wait state
//   wb_stall             register-file port busy, slot is held
//   wb_sel    [NSRC]     one-hot result-mux source select
//   wb_zom    [3]        result-mux constant control
//   wb_valid             register-file write enable
//   wb_addr   [AW]       register-file write address
//   wb_done   [NSRC]     retire pulse to the owning requester
module wb_port_scheduler
  import wb_port_scheduler_pkg::*;
#(
  parameter int NSRC       = NSRC_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int PRIO_SRC   = PRIO_SRC_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NSRC-1:0]        req_valid,
  input  logic [NSRC*ADDR_W-1:0] req_addr,
  input  logic [NSRC*3-1:0]      req_zom,
  output logic [NSRC-1:0]        req_ready,
  input  logic                   flush,
  input  logic                   wb_stall,
  output logic [NSRC-1:0]        wb_sel,
  output logic [2:0]             wb_zom,
  output logic                   wb_valid,
  output logic [ADDR_W-1:0]      wb_addr,
  output logic [NSRC-1:0]        wb_done
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam int PTR_W = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic              wb_valid_q;
  logic [NSRC-1:0]   wb_sel_q;
  logic [2:0]        wb_zom_q;
  logic [ADDR_W-1:0] wb_addr_q;
  logic [PTR_W-1:0]  owner_q;
  logic [PTR_W-1:0]  rr_ptr_q;
  logic [PTR_W-1:0]  rr_ptr_d;
  logic [CNT_W-1:0]  cnt_q [NSRC];

  logic              can_accept;
  logic              retire;
  logic [NSRC-1:0]   starved;
  logic              starve_valid;
  logic [PTR_W-1:0]  starve_idx;
  logic [NSRC-1:0]   prio_mask;
  logic [NSRC-1:0]   rr_gnt;
  logic [PTR_W-1:0]  rr_idx;
  logic              rr_valid;
  logic [NSRC-1:0]   grant_oh;
  logic [PTR_W-1:0]  grant_idx;
  grant_rule_e       grant_rule;
  logic              hs;
  logic [ADDR_W-1:0] hs_addr;
  logic [2:0]        hs_zom;

  assign can_accept = reset_n && !flush && (!wb_valid_q || !wb_stall);
  // A retire is counted even in a flush cycle: the write was already on the port.
  assign retire     = reset_n && wb_valid_q && !wb_stall;
  assign prio_mask  = NSRC'(1) << PRIO_SRC;

  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      starved[i] = req_valid[i] && (cnt_q[i] == CNT_W'(STARVE_MAX));
    end
  end

  // Descending scan so the lowest starved index wins.
  always_comb begin
    starve_valid = 1'b0;
    starve_idx   = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (starved[i]) begin
        starve_valid = 1'b1;
        starve_idx   = PTR_W'(i);
      end
    end
  end

  wb_rr_pick #(.N(NSRC)) u_rr_pick (
    .req_i   (req_valid),
    .excl_i  (prio_mask),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (rr_gnt),
    .idx_o   (rr_idx),
    .valid_o (rr_valid)
  );

  always_comb begin
    grant_oh   = '0;
    grant_idx  = '0;
    grant_rule = GRANT_NONE;
    if (can_accept) begin
      if (req_valid[PRIO_SRC]) begin
        grant_oh   = prio_mask;
        grant_idx  = PTR_W'(PRIO_SRC);
        grant_rule = GRANT_PRIO;
      end else if (starve_valid) begin
        grant_oh   = NSRC'(1) << starve_idx;
        grant_idx  = starve_idx;
        grant_rule = GRANT_STARVE;
      end else if (rr_valid) begin
        grant_oh   = rr_gnt;
        grant_idx  = rr_idx;
        grant_rule = GRANT_RR;
      end
    end
  end

  assign hs        = (grant_rule != GRANT_NONE);
  assign req_ready = grant_oh;

  always_comb begin
    hs_addr = '0;
    hs_zom  = ZOM_DATA;
    for (int i = 0; i < NSRC; i++) begin
      if (grant_oh[i]) begin
        hs_addr = req_addr[i*ADDR_W +: ADDR_W];
        hs_zom  = req_zom[i*3 +: 3];
      end
    end
  end

  assign rr_ptr_d = (grant_idx == PTR_W'(NSRC - 1)) ? '0 : grant_idx + 1'b1;

  // Writeback slot. HELD (valid && stall) falls through every branch and holds.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wb_valid_q <= 1'b0;
      wb_sel_q   <= '0;
      wb_zom_q   <= ZOM_DATA;
      wb_addr_q  <= '0;
      owner_q    <= '0;
    end else if (flush) begin
      wb_valid_q <= 1'b0;
      wb_sel_q   <= '0;
      wb_zom_q   <= ZOM_DATA;
    end else if (hs) begin
      wb_valid_q <= 1'b1;
      wb_addr_q  <= hs_addr;
      wb_zom_q   <= hs_zom;
      wb_sel_q   <= (hs_zom == ZOM_DATA) ? grant_oh : '0;
      owner_q    <= grant_idx;
    end else if (retire) begin
      wb_valid_q <= 1'b0;
      wb_sel_q   <= '0;
      wb_zom_q   <= ZOM_DATA;
    end
  end

  // Only round-robin grants move the pointer; priority and starvation grants
  // must not disturb fairness among the remaining requesters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr_q <= '0;
    end else if (grant_rule == GRANT_RR) begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NSRC; i++) begin
      if (!reset_n || flush) begin
        cnt_q[i] <= '0;
      end else if (!req_valid[i] || grant_oh[i]) begin
        cnt_q[i] <= '0;
      end else if (cnt_q[i] != CNT_W'(STARVE_MAX)) begin
        cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_sel   = wb_sel_q;
  assign wb_zom   = wb_zom_q;
  assign wb_addr  = wb_addr_q;
  assign wb_done  = retire ? (NSRC'(1) << owner_q) : '0;

endmodule

// File: tb/tb_wb_port_scheduler.sv
module tb_wb_port_scheduler;

  localparam int NSRC   = 7;
  localparam int ADDR_W = 5;

  logic                   clk;
  logic                   reset_n;
  logic [NSRC-1:0]        req_valid;
  logic [NSRC*ADDR_W-1:0] req_addr;
  logic [NSRC*3-1:0]      req_zom;
  logic [NSRC-1:0]        req_ready;
  logic                   flush;
  logic                   wb_stall;
  logic [NSRC-1:0]        wb_sel;
  logic [2:0]             wb_zom;
  logic                   wb_valid;
  logic [ADDR_W-1:0]      wb_addr;
  logic [NSRC-1:0]        wb_done;

  int tests;
  int fails;

  wb_port_scheduler dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_zom   (req_zom),
    .req_ready (req_ready),
    .flush     (flush),
    .wb_stall  (wb_stall),
    .wb_sel    (wb_sel),
    .wb_zom    (wb_zom),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .wb_done   (wb_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_addr(input int i, input logic [ADDR_W-1:0] v);
    req_addr[i*ADDR_W +: ADDR_W] = v;
  endtask

  task automatic set_zom(input int i, input logic [2:0] v);
    req_zom[i*3 +: 3] = v;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    reset_n   = 1'b0;
    req_valid = 7'h7F;
    req_addr  = '0;
    req_zom   = '0;
    flush     = 1'b0;
    wb_stall  = 1'b0;

    // Reset held with every requester asking
    tick();
    tick();
    check("rst_ready", 32'(req_ready), 32'h00);
    check("rst_valid", 32'(wb_valid), 32'h0);
    check("rst_sel", 32'(wb_sel), 32'h00);
    check("rst_zom", 32'(wb_zom), 32'h0);
    check("rst_done", 32'(wb_done), 32'h00);
    reset_n = 1'b1;
    settle();
    check("rel_ready_prio", 32'(req_ready), 32'h01);
    req_valid = '0;
    tick();

    // Round-robin between src1 and src2
    set_addr(1, 5'd1);
    set_addr(2, 5'd2);
    req_valid = 7'b0000110;
    settle();
    check("rr_a_ready", 32'(req_ready), 32'h02);
    check("rr_a_valid", 32'(wb_valid), 32'h0);
    tick();
    check("rr_b_sel", 32'(wb_sel), 32'h02);
    check("rr_b_addr", 32'(wb_addr), 32'd1);
    check("rr_b_done", 32'(wb_done), 32'h02);
    check("rr_b_ready", 32'(req_ready), 32'h04);
    tick();
    check("rr_c_sel", 32'(wb_sel), 32'h04);
    check("rr_c_addr", 32'(wb_addr), 32'd2);
    check("rr_c_done", 32'(wb_done), 32'h04);
    check("rr_c_ready", 32'(req_ready), 32'h02);
    tick();
    check("rr_d_sel", 32'(wb_sel), 32'h02);
    check("rr_d_ready", 32'(req_ready), 32'h04);
    tick();
    check("rr_e_sel", 32'(wb_sel), 32'h04);
    req_valid = '0;
    settle();
    check("rr_e_done", 32'(wb_done), 32'h04);
    check("rr_e_ready", 32'(req_ready), 32'h00);
    tick();
    check("rr_f_empty", 32'(wb_valid), 32'h0);
    check("rr_f_done", 32'(wb_done), 32'h00);

    // Constant write: src3, zom = minus-one, addr 9
    set_addr(3, 5'd9);
    set_zom(3, 3'b100);
    req_valid = 7'b0001000;
    settle();
    check("const_ready", 32'(req_ready), 32'h08);
    tick();
    req_valid = '0;
    settle();
    check("const_valid", 32'(wb_valid), 32'h1);
    check("const_addr", 32'(wb_addr), 32'd9);
    check("const_sel", 32'(wb_sel), 32'h00);
    check("const_zom", 32'(wb_zom), 32'h4);
    check("const_done", 32'(wb_done), 32'h08);
    tick();
    check("const_after_valid", 32'(wb_valid), 32'h0);
    check("const_after_zom", 32'(wb_zom), 32'h0);

    // Stall: src2 in slot held three cycles while src5 waits
    req_valid = 7'b0000100;
    settle();
    check("stall_grant2", 32'(req_ready), 32'h04);
    tick();
    set_addr(5, 5'd21);
    req_valid = 7'b0100000;
    wb_stall  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      check("held_ready", 32'(req_ready), 32'h00);
      check("held_done", 32'(wb_done), 32'h00);
      check("held_sel", 32'(wb_sel), 32'h04);
      check("held_addr", 32'(wb_addr), 32'd2);
      tick();
    end
    wb_stall = 1'b0;
    settle();
    check("unstall_done", 32'(wb_done), 32'h04);
    check("unstall_ready", 32'(req_ready), 32'h20);
    tick();
    req_valid = '0;
    settle();
    check("unstall_next_sel", 32'(wb_sel), 32'h20);
    check("unstall_next_addr", 32'(wb_addr), 32'd21);
    check("unstall_next_done", 32'(wb_done), 32'h20);
    tick();

    // Starvation: src0 monopolises the port while src5 counts up to 7
    req_valid = 7'b0100001;
    settle();
    check("starve_prio0", 32'(req_ready), 32'h01);
    for (int k = 0; k < 7; k++) begin
      tick();
      check("starve_prio_ready", 32'(req_ready), 32'h01);
      check("starve_prio_done", 32'(wb_done), 32'h01);
    end
    // src0 drops; src5 (starved) must beat round-robin candidate src4
    req_valid = 7'b0110000;
    set_addr(4, 5'd17);
    settle();
    check("starve_win5", 32'(req_ready), 32'h20);
    tick();
    check("starve_sel5", 32'(wb_sel), 32'h20);
    check("starve_addr5", 32'(wb_addr), 32'd21);
    check("starve_done5", 32'(wb_done), 32'h20);
    check("starve_then_rr4", 32'(req_ready), 32'h10);
    tick();

    // Flush while HELD with src4 / addr 17
    req_valid = 7'b1000000;
    wb_stall  = 1'b1;
    settle();
    check("fl_held_sel", 32'(wb_sel), 32'h10);
    check("fl_held_addr", 32'(wb_addr), 32'd17);
    check("fl_held_ready", 32'(req_ready), 32'h00);
    tick();
    flush = 1'b1;
    settle();
    check("fl_ready", 32'(req_ready), 32'h00);
    check("fl_done", 32'(wb_done), 32'h00);
    tick();
    flush     = 1'b0;
    wb_stall  = 1'b0;
    req_valid = 7'b1111110;
    settle();
    check("fl_after_valid", 32'(wb_valid), 32'h0);
    check("fl_after_sel", 32'(wb_sel), 32'h00);
    check("fl_after_done", 32'(wb_done), 32'h00);
    check("fl_rrptr_kept", 32'(req_ready), 32'h20);
    tick();
    req_valid = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
